bsg_buf_ctrl_stagger: RTL
=========================

BSG_BUF_CTRL_STAGGER -- requirements
Module: bsg_buf_ctrl_stagger

Interface
REQ-001 SHALL have parameter width_p, default 32, number of replicated control lanes driven on o.
REQ-002 SHALL have parameter els_per_group_p, default 8, lanes switched together per step; last group partial when width_p is not a multiple.
REQ-003 SHALL have parameter dwell_p, default 4, minimum cycles between consecutive steps; legal range >= 1.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n_i  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port en_i  input  1  level request: 1 = all lanes on, 0 = all lanes off.
REQ-007 SHALL have port o  output  width_p  per-lane control; bit k belongs to group k/els_per_group_p.
REQ-008 SHALL have port ready_o  output  1  all groups on.
REQ-009 SHALL have port idle_o  output  1  all groups off.
REQ-010 SHALL have port busy_o  output  1  ramp in progress (state RAMP_UP or RAMP_DOWN).

Function
REQ-011 SHALL define G = ceil(width_p/els_per_group_p) and a group counter cnt in 0..G, width $clog2(G+1).
REQ-012 SHALL drive o as a thermometer: group j fully asserted iff j < cnt; o registered from cnt, no combinational path from en_i.
REQ-013 SHALL define target = G when en_i=1, else 0, sampled each rising edge.
REQ-014 SHALL keep dwell counter dw saturating at dwell_p-1; on any step, dw becomes 0; otherwise dw increments to saturation.
REQ-015 SHALL take one step (cnt +/-1 toward target) at an edge iff cnt != target and dw == dwell_p-1; never more than one group per step.
REQ-016 SHALL implement FSM IDLE (cnt=0), RAMP_UP, FULL (cnt=G), RAMP_DOWN; IDLE->RAMP_UP and FULL->RAMP_DOWN on the step edge; RAMP_UP->FULL and RAMP_DOWN->IDLE when cnt reaches its end value.
REQ-017 SHALL reverse direction mid-ramp when en_i toggles, without resetting dw; next step in new direction no sooner than dwell_p cycles after the previous step.
REQ-018 SHALL make first step out of IDLE or FULL immediate if dw is saturated (at least dwell_p cycles since last step).
REQ-019 SHALL assert ready_o iff cnt==G, idle_o iff cnt==0, busy_o iff state is RAMP_UP or RAMP_DOWN; all registered-state decodes.
REQ-020 SHALL tolerate en_i pulses shorter than dwell_p: at most one step is taken per dwell window.
REQ-021 SHALL, for dwell_p=1, step on every edge; for G=1, move directly IDLE<->FULL in one edge.

Reset
REQ-022 SHALL on reset_n_i=0 immediately force state IDLE, cnt=0, dw=dwell_p-1, o=0, idle_o=1, ready_o=0, busy_o=0, regardless of clock.
REQ-023 SHALL, on reset mid-ramp, drop all lanes at once (not staggered); first step after release per REQ-015.

Structure
REQ-024 SHALL place the FSM state enum (IDLE, RAMP_UP, FULL, RAMP_DOWN) in a shared package bsg_buf_ctrl_stagger_pkg.
REQ-025 SHALL instantiate one bsg_buf_ctrl per group to fan the group enable bit to its lanes; the partial last group is sliced to width.
REQ-026 SHALL keep cnt, dw and state as the only flops; no other sub-modules.

Verification
REQ-027 Defaults, en_i 0->1 at edge 0 -> o=0x000000FF after edge 0, 0x0000FFFF after edge 4, 0x00FFFFFF after edge 8, 0xFFFFFFFF and ready_o=1 after edge 12; busy_o=1 edges 0..11.
REQ-028 From FULL with dw saturated, en_i->0 -> o=0x00FFFFFF next edge, then 0x0000FFFF, 0x000000FF, 0 at 4-cycle spacing; idle_o=1 at end.
REQ-029 Ramp up to o=0x0000FFFF, drop en_i 1 cycle after that step -> o=0x000000FF exactly 4 cycles after the previous step, then 0.
REQ-030 reset_n_i low asynchronously while o=0x00FFFFFF -> o=0, idle_o=1 before next clock edge; release with en_i=1 -> o=0x000000FF at first edge.
REQ-031 width_p=20, els_per_group_p=8, dwell_p=1 -> o steps 0x000FF, 0x0FFFF, 0xFFFFF on consecutive edges; ready_o on third.
REQ-032 en_i 1-cycle pulse from IDLE -> single step to 0x000000FF, back to 0 four cycles later; no further activity.

Source files
------------

// File: rtl/bsg_buf_ctrl_stagger_pkg.sv
// -----------------------------------------------------------------------------
// bsg_buf_ctrl_stagger_pkg
// Shared definitions for the staggered buffer-control block.
//   state_e  : ramp FSM state encoding (IDLE, RAMP_UP, FULL, RAMP_DOWN)
//   ceil_div : integer ceiling division, used to size the group count
// -----------------------------------------------------------------------------
package bsg_buf_ctrl_stagger_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    FULL      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/bsg_buf_ctrl_stagger_buf_ctrl.sv
// -----------------------------------------------------------------------------
// bsg_buf_ctrl
// Fans one control bit out to width_p identical lanes.
//   i : control bit
//   o : width_p copies of i
// -----------------------------------------------------------------------------
module bsg_buf_ctrl #(
  parameter int width_p = 1
) (
  input  logic               i,
  output logic [width_p-1:0] o
);

  assign o = {width_p{i}};

endmodule

// File: rtl/bsg_buf_ctrl_stagger.sv
// -----------------------------------------------------------------------------
// bsg_buf_ctrl_stagger
// Turns a level request into a staggered, group-by-group ramp of replicated
// control lanes, so that large loads switch on/off a few lanes at a time.
// At most one group moves per step and consecutive steps are spaced by at
// least dwell_p cycles.
//   clk_i     : clock, all state on rising edge
//   reset_n_i : asynchronous active-low reset
//   en_i      : 1 = ramp all lanes on, 0 = ramp all lanes off
//   o         : per-lane control, bit k belongs to group k/els_per_group_p
//   ready_o   : all groups on
//   idle_o    : all groups off
//   busy_o    : ramp in progress
// -----------------------------------------------------------------------------
module bsg_buf_ctrl_stagger
  import bsg_buf_ctrl_stagger_pkg::*;
#(
  parameter int width_p         = 32,
  parameter int els_per_group_p = 8,
  parameter int dwell_p         = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  output logic [width_p-1:0] o,
  output logic               ready_o,
  output logic               idle_o,
  output logic               busy_o
);

  localparam int GRP_N = ceil_div(width_p, els_per_group_p);
  localparam int CNT_W = $clog2(GRP_N + 1);
  // dwell_p == 1 would give a zero-width counter; keep one bit that never moves
  localparam int DW_W  = (dwell_p > 1) ? $clog2(dwell_p) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(GRP_N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DW_W-1:0]  DW_SAT   = DW_W'(dwell_p - 1);
  localparam logic [DW_W-1:0]  DW_ONE   = DW_W'(1);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [DW_W-1:0]  r_dw;
  logic [DW_W-1:0]  w_dw_next;
  logic [CNT_W-1:0] w_target;
  logic             w_step;
  logic             w_up;
  logic [GRP_N-1:0] w_grp_en;

  // ---------------------------------------------------------------------------
  // Step decision: move one group toward the target once the dwell window
  // has fully elapsed. Direction follows en_i directly, so a mid-ramp toggle
  // reverses without disturbing the dwell counter.
  // ---------------------------------------------------------------------------
  assign w_target = en_i ? CNT_FULL : '0;
  assign w_step   = (r_cnt != w_target) && (r_dw == DW_SAT);
  assign w_up     = en_i;

  always_comb begin
    w_cnt_next = r_cnt;
    w_dw_next  = r_dw;
    if (w_step) begin
      w_cnt_next = w_up ? (r_cnt + CNT_ONE) : (r_cnt - CNT_ONE);
      w_dw_next  = '0;
    end else if (r_dw != DW_SAT) begin
      w_dw_next  = r_dw + DW_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt <= '0;
      r_dw  <= DW_SAT;
    end else begin
      r_cnt <= w_cnt_next;
      r_dw  <= w_dw_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Only a step edge changes state; the end-value checks come
  // first so a single-group configuration jumps straight IDLE<->FULL.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (w_step) begin
      if (w_cnt_next == CNT_FULL) begin
        w_state_next = FULL;
      end else if (w_cnt_next == '0) begin
        w_state_next = IDLE;
      end else if (w_up) begin
        w_state_next = RAMP_UP;
      end else begin
        w_state_next = RAMP_DOWN;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_o = (r_cnt == CNT_FULL);
    idle_o  = (r_cnt == '0);
    busy_o  = (r_state == RAMP_UP) || (r_state == RAMP_DOWN);
  end

  // ---------------------------------------------------------------------------
  // Thermometer decode of the group counter, fanned out per group. The last
  // group is trimmed when width_p is not a multiple of the group size.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < GRP_N; gi++) begin : g_grp
      localparam int LO = gi * els_per_group_p;
      localparam int HI = ((LO + els_per_group_p) < width_p) ?
                          (LO + els_per_group_p - 1) : (width_p - 1);

      assign w_grp_en[gi] = (r_cnt > CNT_W'(gi));

      bsg_buf_ctrl #(
        .width_p(HI - LO + 1)
      ) u_buf (
        .i(w_grp_en[gi]),
        .o(o[HI:LO])
      );
    end
  endgenerate

endmodule
